// File: rtl/sum_accumulator.sv
// sum_accumulator
//
// Accumulates COUNT signed samples per block from an upstream adder and
// presents each block total on a registered output. Accumulation of the
// next block carries on while the previous total waits for the consumer;
// only the final sample of a block can stall, and only while an older
// result is still unconsumed.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid && !ready. out_acc
// and out_sat are stable while out_valid && !out_ready.
//
// Parameters:
//   IN_WIDTH   width of the signed input sample
//   ACC_WIDTH  width of the signed accumulator and output (>= IN_WIDTH)
//   COUNT      samples per block (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (discards partial block and
//              any pending result)
//   in_sum     signed input sample
//   in_valid   sample present
//   in_ready   sample accepted this cycle (combinational from cnt, out_valid,
//              out_ready only)
//   out_acc    signed block total
//   out_valid  out_acc/out_sat valid
//   out_ready  consumer takes the result this cycle
//   out_sat    a clamp occurred inside this block
//
// Build option:
//   SUM_ACCUMULATOR_SAT_EN  when defined, every addition clamps to the
//                           ACC_WIDTH signed range and out_sat reports any
//                           clamp within the block. When undefined, additions
//                           wrap modulo 2^ACC_WIDTH and out_sat is tied 0.

module sum_accumulator #(
    parameter int IN_WIDTH  = 18,
    parameter int ACC_WIDTH = 24,
    parameter int COUNT     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_sum,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sat
);

    localparam int CNT_W = $clog2(COUNT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;

    logic signed [IN_WIDTH-1:0]  in_s;
    logic        [ACC_WIDTH-1:0] in_ext;
    logic        [ACC_WIDTH-1:0] next_acc;
    logic                        add_sat;
    logic                        last;
    logic                        accept;
    logic                        final_accept;

    assign last         = (cnt == LAST);
    // Only the final sample of a block needs the result register to be free.
    assign in_ready     = !(last && out_valid && !out_ready);
    assign accept       = in_valid && in_ready;
    assign final_accept = accept && last;

    // Sign extension of the sample to accumulator width.
    assign in_s   = in_sum;
    assign in_ext = ACC_WIDTH'(in_s);

`ifdef SUM_ACCUMULATOR_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // One guard bit: overflow when the top two bits of the widened sum differ.
    logic [ACC_WIDTH:0] wide;

    always_comb begin
        wide     = {acc[ACC_WIDTH-1], acc} + {in_ext[ACC_WIDTH-1], in_ext};
        next_acc = wide[ACC_WIDTH-1:0];
        add_sat  = 1'b0;
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            add_sat  = 1'b1;
            next_acc = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        next_acc = acc + in_ext;
        add_sat  = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_acc   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    out_acc <= next_acc;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= next_acc;
                    cnt <= cnt + 1'b1;
                end
            end
            // A fresh result wins over consumption of the old one.
            if (final_accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SUM_ACCUMULATOR_SAT_EN
    logic sat_sticky;
    logic sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_sticky <= 1'b0;
            sat_q      <= 1'b0;
        end else if (accept) begin
            if (last) begin
                sat_q      <= sat_sticky | add_sat;
                sat_sticky <= 1'b0;
            end else begin
                sat_sticky <= sat_sticky | add_sat;
            end
        end
    end

    assign out_sat = sat_q;
`else
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

    localparam int IW  = 18;
    localparam int AW  = 19;
    localparam int CNT = 4;
    localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (AW - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] in_sum;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] out_acc;
    logic          out_valid;
    logic          out_ready;
    logic          out_sat;

    sum_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .COUNT(CNT)) dut (
        .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid),
        .in_ready(in_ready), .out_acc(out_acc), .out_valid(out_valid),
        .out_ready(out_ready), .out_sat(out_sat)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    logic          exp_sat_q[$];
    int            exp_cyc_q[$];
    int            n_out = 0;
    longint        last_acc = 0;
    logic          last_sat = 1'b0;
    bit            rand_done = 1'b0;

    // Reference model: block sum kept as a plain integer.
    longint m_sum = 0;
    int     m_cnt = 0;
    logic   m_sat = 1'b0;

    function automatic longint sval(input logic [AW-1:0] v);
        logic signed [AW-1:0] s;
        s = v;
        return longint'(s);
    endfunction

    function automatic longint wrap(input longint v);
        longint m;
        m = v & ((64'sd1 <<< AW) - 1);
        if (m > MAXV) m = m - (64'sd1 <<< AW);
        return m;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_add(input logic [IW-1:0] s, input int vis_cyc);
        logic signed [IW-1:0] ss;
        longint t;
        ss = s;
        t = m_sum + longint'(ss);
`ifdef SUM_ACCUMULATOR_SAT_EN
        if (t > MAXV) begin t = MAXV; m_sat = 1'b1; end
        else if (t < MINV) begin t = MINV; m_sat = 1'b1; end
`else
        t = wrap(t);
`endif
        m_sum = t;
        m_cnt++;
        if (m_cnt == CNT) begin
            exp_q.push_back(AW'(m_sum));
            exp_sat_q.push_back(m_sat);
            exp_cyc_q.push_back(vis_cyc);
            m_sum = 0;
            m_cnt = 0;
            m_sat = 1'b0;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit prev_valid;
        bit prev_hs;
        bit new_res;
        logic [AW-1:0] held_acc;
        logic          held_sat;
        prev_valid = 0;
        prev_hs = 0;
        held_acc = '0;
        held_sat = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0;
                prev_hs = 0;
            end else begin
                if (out_valid) begin
                    new_res = !prev_valid || prev_hs;
                    if (new_res) begin
                        if (exp_cyc_q.size() > 0) check("latency", cyc, exp_cyc_q[0]);
                    end else begin
                        check("hold_acc", sval(out_acc), sval(held_acc));
                        check("hold_sat", out_sat, held_sat);
                    end
                    held_acc = out_acc;
                    held_sat = out_sat;
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_output: got %0d, expected none", sval(out_acc));
                        end else begin
                            check("out_acc", sval(out_acc), sval(exp_q.pop_front()));
                            check("out_sat", out_sat, exp_sat_q.pop_front());
                            void'(exp_cyc_q.pop_front());
                            last_acc = sval(out_acc);
                            last_sat = out_sat;
                            n_out++;
                        end
                    end
                end
                prev_valid = out_valid;
                prev_hs = out_valid && out_ready;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [IW-1:0] v, output int stalls);
        int vis;
        bit ok;
        in_valid = 1'b1;
        in_sum = v;
        stalls = 0;
        ok = 0;
        vis = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                vis = cyc + 1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for 64 cycles, expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_add(v, vis);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_n(input logic [IW-1:0] v, input int n, output int total_stalls);
        int s;
        total_stalls = 0;
        for (int i = 0; i < n; i++) begin
            send(v, s);
            total_stalls += s;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_sat_q.delete();
        exp_cyc_q.delete();
        m_sum = 0;
        m_cnt = 0;
        m_sat = 1'b0;
    endtask

    task automatic wait_out(input int n_before);
        bit ok;
        ok = 0;
        for (int k = 0; k < 32; k++) begin
            if (n_out > n_before) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_out_timeout: got %0d results, expected > %0d", n_out, n_before);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] rand_sample();
        case ($urandom_range(0, 5))
            0: return 18'h1FFFF;
            1: return 18'h20000;
            default: return IW'($urandom_range(0, (1 << IW) - 1));
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int st;
        int n0;
        logic [IW-1:0] v4 [4];

        rst = 1'b1;
        in_valid = 1'b0;
        in_sum = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        check("reset_out_valid", out_valid, 0);
        check("reset_out_acc", sval(out_acc), 0);
        check("reset_out_sat", out_sat, 0);
        check("reset_in_ready", in_ready, 1);

        // Basic block
        v4[0] = 18'd12252;
        v4[1] = IW'(-27688);
        v4[2] = 18'd8857;
        v4[3] = IW'(-4323);
        n0 = n_out;
        for (int i = 0; i < 4; i++) send(v4[i], st);
        wait_out(n0);
        check("basic_acc", last_acc, -10902);
        check("basic_sat", last_sat, 0);
        idle(2);
        check("basic_single_cycle", out_valid, 0);

        // Back-to-back blocks
        n0 = n_out;
        begin
            int s1;
            int s2;
            send_n(18'd1, 8, s1);
            send_n(IW'(-2), 8, s2);
            check("b2b_no_stall", s1 + s2, 0);
        end
        idle(3);
        check("b2b_results", n_out - n0, 4);
        check("b2b_last", last_acc, -8);

        // Backpressure
        out_ready = 1'b0;
        send_n(18'd1, 7, st);
        check("bp_first7_no_stall", st, 0);
        n0 = n_out;
        fork
            send(18'd1, st);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", in_ready, 0);
                    check("bp_held_acc", sval(out_acc), 4);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp_stalls", st, 3);
        check("bp_first_consumed", n_out - n0, 1);
        wait_out(n0 + 1);
        check("bp_second_acc", last_acc, 4);

        // Saturation
        n0 = n_out;
        send_n(18'h1FFFF, 4, st);
        wait_out(n0);
`ifdef SUM_ACCUMULATOR_SAT_EN
        check("sat_acc", last_acc, 262143);
        check("sat_flag", last_sat, 1);
`else
        check("wrap_acc", last_acc, -4);
        check("wrap_flag", last_sat, 0);
`endif
        n0 = n_out;
        send_n(18'd1, 4, st);
        wait_out(n0);
        check("after_sat_acc", last_acc, 4);
        check("after_sat_flag", last_sat, 0);

        // Reset mid-block
        n0 = n_out;
        send_n(18'd100, 3, st);
        idle(1);
        do_reset();
        send_n(18'd5, 4, st);
        wait_out(n0);
        check("rst_mid_acc", last_acc, 20);
        check("rst_mid_count", n_out - n0, 1);

        // Reset with result pending
        out_ready = 1'b0;
        send_n(18'd7, 4, st);
        idle(2);
        check("pend_valid", out_valid, 1);
        check("pend_acc", sval(out_acc), 28);
        do_reset();
        check("pend_rst_valid", out_valid, 0);
        check("pend_rst_acc", sval(out_acc), 0);
        out_ready = 1'b1;
        idle(2);

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 240; i++) begin
                    send(rand_sample(), st);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(10);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
